// File: rtl/qrd_pkg.sv
// rtl/qrd_pkg.sv - shared defaults, state encoding and round/saturate helper for the QRD-RLS cells
package qrd_pkg;

    localparam int QRD_DEF_DATA_LENGTH = 8;
    // cos/sine are Q1.(DATA_LENGTH-2): one sign bit, one integer bit
    localparam int QRD_ROT_GUARD       = 2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HAVE_ROT = 3'd1,
        ST_HAVE_X   = 3'd2,
        ST_FORGET   = 3'd3,
        ST_MULT     = 3'd4,
        ST_SUM      = 3'd5
    } qrd_state_e;

    // Round half-up, arithmetic shift right by frac, clamp to a dl-bit signed range
    function automatic logic signed [63:0] qrd_round_sat_f(
        input logic signed [63:0] v,
        input int                 frac,
        input int                 dl
    );
        logic signed [63:0] rounded;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        rounded = (v + (64'sd1 <<< (frac - 1))) >>> frac;
        max_v   = (64'sd1 <<< (dl - 1)) - 64'sd1;
        min_v   = -(64'sd1 <<< (dl - 1));
        if (rounded > max_v) begin
            return max_v;
        end else if (rounded < min_v) begin
            return min_v;
        end
        return rounded;
    endfunction

endpackage

// File: rtl/qrd_round_sat.sv
// rtl/qrd_round_sat.sv - combinational round, arithmetic shift and clamp of a wide product/sum
module qrd_round_sat
    import qrd_pkg::*;
#(
    parameter int IN_W        = 17,
    parameter int DATA_LENGTH = 8,
    parameter int ROT_FRAC    = 6
) (
    input  logic signed [IN_W-1:0]        din,
    output logic signed [DATA_LENGTH-1:0] dout
);

    // Result always lies inside the DATA_LENGTH range, so the low bits carry the full value
    assign dout = DATA_LENGTH'(qrd_round_sat_f(64'(din), ROT_FRAC, DATA_LENGTH));

endmodule

// File: rtl/qrd_internal_cell.sv
// rtl/qrd_internal_cell.sv - QRD-RLS internal rotation cell; optional QRD_FORGET_EN adds lambda scaling of r
module qrd_internal_cell
    import qrd_pkg::*;
#(
    parameter int DATA_LENGTH = QRD_DEF_DATA_LENGTH,
    parameter int ROT_FRAC    = DATA_LENGTH - QRD_ROT_GUARD,
    parameter int LAMBDA      = (1 << ROT_FRAC) - 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic                          rot_valid,
    input  logic signed [DATA_LENGTH-1:0] cos_in,
    input  logic signed [DATA_LENGTH-1:0] sine_in,
    input  logic                          x_valid,
    input  logic signed [DATA_LENGTH-1:0] x_in,
    output logic                          busy,
    output logic                          overrun,
    output logic                          rot_valid_out,
    output logic signed [DATA_LENGTH-1:0] cos_out,
    output logic signed [DATA_LENGTH-1:0] sine_out,
    output logic                          x_valid_out,
    output logic signed [DATA_LENGTH-1:0] x_out,
    output logic signed [DATA_LENGTH-1:0] r_out
);

    localparam int PW = 2 * DATA_LENGTH;
    localparam int SW = PW + 1;

`ifdef QRD_FORGET_EN
    localparam qrd_state_e PAIR_NEXT = ST_FORGET;
`else
    localparam qrd_state_e PAIR_NEXT = ST_MULT;
`endif

    qrd_state_e state_q, state_d;

    logic signed [DATA_LENGTH-1:0] cos_q, sin_q, x_q, r_q;
    logic signed [PW-1:0]          p_cr_q, p_sx_q, p_cx_q, p_sr_q;
    logic signed [DATA_LENGTH-1:0] r_out_q, x_out_q, cos_out_q, sine_out_q;
    logic                          rot_valid_out_q, x_valid_out_q, overrun_q;

    logic                          capture;
    logic                          drop;
    logic                          busy_w;
    logic signed [SW-1:0]          sum_r, sum_x;
    logic signed [DATA_LENGTH-1:0] r_new, x_new;

    assign sum_r = SW'(p_cr_q) + SW'(p_sx_q);
    assign sum_x = SW'(p_cx_q) - SW'(p_sr_q);

    qrd_round_sat #(
        .IN_W        (SW),
        .DATA_LENGTH (DATA_LENGTH),
        .ROT_FRAC    (ROT_FRAC)
    ) u_rs_r (
        .din  (sum_r),
        .dout (r_new)
    );

    qrd_round_sat #(
        .IN_W        (SW),
        .DATA_LENGTH (DATA_LENGTH),
        .ROT_FRAC    (ROT_FRAC)
    ) u_rs_x (
        .din  (sum_x),
        .dout (x_new)
    );

`ifdef QRD_FORGET_EN
    localparam logic signed [DATA_LENGTH-1:0] LAMBDA_Q = DATA_LENGTH'(LAMBDA);
    logic signed [PW-1:0]          forget_prod;
    logic signed [DATA_LENGTH-1:0] r_forget;

    assign forget_prod = PW'(LAMBDA_Q) * PW'(r_q);

    qrd_round_sat #(
        .IN_W        (PW),
        .DATA_LENGTH (DATA_LENGTH),
        .ROT_FRAC    (ROT_FRAC)
    ) u_rs_forget (
        .din  (forget_prod),
        .dout (r_forget)
    );
`else
    logic [31:0] lambda_unused;
    assign lambda_unused = 32'(LAMBDA);
`endif

    // Next state: gather a cos/sine and an x strobe, then walk the fixed datapath pipeline.
    // SUM retires a result on its closing edge, so it accepts new strobes exactly like IDLE.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        drop    = 1'b0;
        busy_w  = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_SUM: begin
                capture = 1'b1;
                busy_w  = (state_q == ST_SUM);
                if (rot_valid && x_valid) begin
                    state_d = PAIR_NEXT;
                end else if (rot_valid) begin
                    state_d = ST_HAVE_ROT;
                end else if (x_valid) begin
                    state_d = ST_HAVE_X;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HAVE_ROT: begin
                capture = 1'b1;
                if (x_valid) begin
                    state_d = PAIR_NEXT;
                end
            end
            ST_HAVE_X: begin
                capture = 1'b1;
                if (rot_valid) begin
                    state_d = PAIR_NEXT;
                end
            end
            ST_FORGET: begin
                busy_w  = 1'b1;
                drop    = rot_valid || x_valid;
                state_d = ST_MULT;
            end
            ST_MULT: begin
                busy_w  = 1'b1;
                drop    = rot_valid || x_valid;
                state_d = ST_SUM;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, operand latches, product pipeline and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            cos_q           <= '0;
            sin_q           <= '0;
            x_q             <= '0;
            r_q             <= '0;
            p_cr_q          <= '0;
            p_sx_q          <= '0;
            p_cx_q          <= '0;
            p_sr_q          <= '0;
            r_out_q         <= '0;
            x_out_q         <= '0;
            cos_out_q       <= '0;
            sine_out_q      <= '0;
            rot_valid_out_q <= 1'b0;
            x_valid_out_q   <= 1'b0;
            overrun_q       <= 1'b0;
        end else if (clear) begin
            // Abort: anything in flight is discarded and never emitted
            state_q         <= ST_IDLE;
            cos_q           <= '0;
            sin_q           <= '0;
            x_q             <= '0;
            r_q             <= '0;
            r_out_q         <= '0;
            rot_valid_out_q <= 1'b0;
            x_valid_out_q   <= 1'b0;
            overrun_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            rot_valid_out_q <= 1'b0;
            x_valid_out_q   <= 1'b0;
            if (capture && rot_valid) begin
                cos_q <= cos_in;
                sin_q <= sine_in;
            end
            if (capture && x_valid) begin
                x_q <= x_in;
            end
            if (drop) begin
                overrun_q <= 1'b1;
            end
`ifdef QRD_FORGET_EN
            if (state_q == ST_FORGET) begin
                r_q <= r_forget;
            end
`endif
            if (state_q == ST_MULT) begin
                p_cr_q <= PW'(cos_q) * PW'(r_q);
                p_sx_q <= PW'(sin_q) * PW'(x_q);
                p_cx_q <= PW'(cos_q) * PW'(x_q);
                p_sr_q <= PW'(sin_q) * PW'(r_q);
            end
            if (state_q == ST_SUM) begin
                // cos_q/sin_q still hold the rotation just applied (non-blocking)
                r_q             <= r_new;
                r_out_q         <= r_new;
                x_out_q         <= x_new;
                cos_out_q       <= cos_q;
                sine_out_q      <= sin_q;
                rot_valid_out_q <= 1'b1;
                x_valid_out_q   <= 1'b1;
            end
        end
    end

    assign busy          = busy_w;
    assign overrun       = overrun_q;
    assign rot_valid_out = rot_valid_out_q;
    assign x_valid_out   = x_valid_out_q;
    assign cos_out       = cos_out_q;
    assign sine_out      = sine_out_q;
    assign x_out         = x_out_q;
    assign r_out         = r_out_q;

endmodule

// File: tb/tb_qrd_internal_cell.sv
// tb/tb_qrd_internal_cell.sv - self-checking bench for qrd_internal_cell against an arithmetic reference
module tb_qrd_internal_cell;

    localparam int DL     = 8;
    localparam int RF     = 6;
    localparam int LAMBDA = 32;
    localparam int MAXV   = (1 << (DL - 1)) - 1;
    localparam int MINV   = -(1 << (DL - 1));
`ifdef QRD_FORGET_EN
    localparam bit FORGET = 1'b1;
    localparam int LAT    = 3;
`else
    localparam bit FORGET = 1'b0;
    localparam int LAT    = 2;
`endif

    logic                 clk, rst, clear, rot_valid, x_valid;
    logic signed [DL-1:0] cos_in, sine_in, x_in;
    logic                 busy, overrun, rot_valid_out, x_valid_out;
    logic signed [DL-1:0] cos_out, sine_out, x_out, r_out;

    int errors = 0;
    int checks = 0;

    // Reference state: stored r, last emitted outputs, sticky overrun
    int mdl_r, mdl_xo, mdl_co, mdl_so;
    bit mdl_ovr;

    qrd_internal_cell #(
        .DATA_LENGTH (DL),
        .ROT_FRAC    (RF),
        .LAMBDA      (LAMBDA)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .clear         (clear),
        .rot_valid     (rot_valid),
        .cos_in        (cos_in),
        .sine_in       (sine_in),
        .x_valid       (x_valid),
        .x_in          (x_in),
        .busy          (busy),
        .overrun       (overrun),
        .rot_valid_out (rot_valid_out),
        .cos_out       (cos_out),
        .sine_out      (sine_out),
        .x_valid_out   (x_valid_out),
        .x_out         (x_out),
        .r_out         (r_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int rsat(input int v);
        int t;
        t = (v + (1 <<< (RF - 1))) >>> RF;
        if (t > MAXV) t = MAXV;
        if (t < MINV) t = MINV;
        return t;
    endfunction

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ":busy"}, busy, 0);
        check({tag, ":overrun"}, overrun, 0);
        check({tag, ":rot_valid_out"}, rot_valid_out, 0);
        check({tag, ":x_valid_out"}, x_valid_out, 0);
        check({tag, ":cos_out"}, cos_out, 0);
        check({tag, ":sine_out"}, sine_out, 0);
        check({tag, ":x_out"}, x_out, 0);
        check({tag, ":r_out"}, r_out, 0);
    endtask

    // mode 0: normal, 1: x strobe during MULT, 2: clear during SUM, 3: async rst during MULT
    task automatic apply(input int c, input int s, input int x, input int gap,
                         input bit x_first, input bit dup, input int mode, input string tag);
        int r_eff, er, ex;
        r_eff = FORGET ? rsat(LAMBDA * mdl_r) : mdl_r;
        er    = rsat(c * r_eff + s * x);
        ex    = rsat(c * x - s * r_eff);

        @(negedge clk);
        if (gap == 0) begin
            rot_valid = 1'b1; cos_in = 8'(c); sine_in = 8'(s);
            x_valid   = 1'b1; x_in   = 8'(x);
        end else begin
            if (dup) begin
                if (x_first) begin
                    x_valid = 1'b1; x_in = 8'($urandom);
                end else begin
                    rot_valid = 1'b1; cos_in = 8'($urandom); sine_in = 8'($urandom);
                end
                @(negedge clk);
            end
            if (x_first) begin
                x_valid = 1'b1; x_in = 8'(x);
            end else begin
                rot_valid = 1'b1; cos_in = 8'(c); sine_in = 8'(s);
            end
            @(negedge clk);
            rot_valid = 1'b0; x_valid = 1'b0;
            repeat (gap - 1) @(negedge clk);
            if (x_first) begin
                rot_valid = 1'b1; cos_in = 8'(c); sine_in = 8'(s);
            end else begin
                x_valid = 1'b1; x_in = 8'(x);
            end
        end
        @(negedge clk);
        rot_valid = 1'b0; x_valid = 1'b0;

        for (int k = 1; k <= LAT; k++) begin
            check({tag, ":busy"}, busy, 1);
            check({tag, ":x_valid_out_early"}, x_valid_out, 0);
            check({tag, ":rot_valid_out_early"}, rot_valid_out, 0);
            check({tag, ":overrun"}, overrun, 32'(mdl_ovr));
            if (mode == 1 && k == LAT - 1) begin
                x_valid = 1'b1; x_in = 8'sd99; mdl_ovr = 1'b1;
            end
            if (mode == 2 && k == LAT) begin
                clear = 1'b1;
            end
            if (mode == 3 && k == LAT - 1) begin
                #2 rst = 1'b1;
                #1 check_all_zero({tag, ":async"});
                @(negedge clk);
                rst = 1'b0;
                mdl_r = 0; mdl_xo = 0; mdl_co = 0; mdl_so = 0; mdl_ovr = 1'b0;
                return;
            end
            @(negedge clk);
            x_valid = 1'b0;
        end

        if (mode == 2) begin
            clear = 1'b0;
            check({tag, ":x_valid_out"}, x_valid_out, 0);
            check({tag, ":rot_valid_out"}, rot_valid_out, 0);
            check({tag, ":r_out"}, r_out, 0);
            check({tag, ":overrun"}, overrun, 0);
            check({tag, ":busy"}, busy, 0);
            check({tag, ":x_out_held"}, x_out, mdl_xo);
            mdl_r = 0; mdl_ovr = 1'b0;
            return;
        end

        check({tag, ":busy_done"}, busy, 0);
        check({tag, ":x_valid_out"}, x_valid_out, 1);
        check({tag, ":rot_valid_out"}, rot_valid_out, 1);
        check({tag, ":x_out"}, x_out, ex);
        check({tag, ":r_out"}, r_out, er);
        check({tag, ":cos_out"}, cos_out, c);
        check({tag, ":sine_out"}, sine_out, s);
        check({tag, ":overrun_after"}, overrun, 32'(mdl_ovr));
        mdl_r = er; mdl_xo = ex; mdl_co = c; mdl_so = s;

        @(negedge clk);
        check({tag, ":x_valid_out_drop"}, x_valid_out, 0);
        check({tag, ":rot_valid_out_drop"}, rot_valid_out, 0);
        check({tag, ":x_out_hold"}, x_out, mdl_xo);
        check({tag, ":r_out_hold"}, r_out, mdl_r);
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0;
        rot_valid = 1'b0; x_valid = 1'b0;
        cos_in = '0; sine_in = '0; x_in = '0;
        mdl_r = 0; mdl_xo = 0; mdl_co = 0; mdl_so = 0; mdl_ovr = 1'b0;

        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("post_reset");

        apply(64, 0, 20, 0, 1'b0, 1'b0, 0, "identity");
        apply(0, 64, 20, 0, 1'b0, 1'b0, 0, "swap");
        apply(45, 45, 10, 3, 1'b0, 1'b0, 0, "split");
        apply(0, 64, 100, 0, 1'b0, 1'b0, 0, "load100");
        apply(64, 64, 100, 0, 1'b0, 1'b0, 0, "saturate");
        apply(45, -45, 30, 2, 1'b1, 1'b0, 0, "x_first");
        apply(64, 0, -50, 1, 1'b0, 1'b1, 0, "rot_latest_wins");
        apply(0, -64, 77, 2, 1'b1, 1'b1, 0, "x_latest_wins");

        for (int i = 0; i < 24; i++) begin
            apply(int'($urandom_range(128)) - 64, int'($urandom_range(128)) - 64,
                  int'($urandom_range(255)) - 128, int'($urandom_range(3)),
                  1'($urandom), 1'($urandom), 0, "random");
        end

        apply(45, 45, 60, 0, 1'b0, 1'b0, 1, "overrun_mult");
        apply(64, 0, 33, 0, 1'b0, 1'b0, 2, "clear_sum");
        apply(64, 0, 12, 0, 1'b0, 1'b0, 0, "after_clear");
        apply(0, 64, 55, 0, 1'b0, 1'b0, 0, "load55");
        apply(45, 45, 10, 0, 1'b0, 1'b0, 3, "rst_mult");
        apply(64, 0, 20, 0, 1'b0, 1'b0, 0, "after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
